// File: rtl/fixp_defs.sv
// Shared fixed-point constants and FSM encodings for the series-term datapath.
package fixp_defs;
    localparam int          FRAC   = 11;
    localparam logic [15:0] ONE    = 16'h0800;
    localparam logic [15:0] MAXPOS = 16'h7FFF;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, MSB first, one quotient bit per clock.
module seq_divider #(
    parameter int W  = 16,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          custom_reset,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [NW-1:0] divisor,
    output logic [W-1:0]  quotient,
    output logic          q_valid
);
    localparam int CW = $clog2(W);

    logic          running;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shreg;
    logic [NW-1:0] rem;
    logic [NW-1:0] dvs;

    logic [NW:0]   trial;
    logic [NW:0]   diff;
    logic          fits;
    logic [NW-1:0] rem_next;

    // The dividend register doubles as the quotient accumulator.
    always_comb begin
        trial    = {rem, shreg[W-1]};
        diff     = trial - {1'b0, dvs};
        fits     = (trial >= {1'b0, dvs});
        rem_next = fits ? diff[NW-1:0] : trial[NW-1:0];
    end

    // Final quotient is presented in the cycle its last bit is resolved.
    assign quotient = {shreg[W-2:0], fits};
    assign q_valid  = running && (cnt == CW'(W - 1));

    always_ff @(posedge clk or posedge custom_reset) begin
        if (custom_reset) begin
            running <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            rem     <= '0;
            dvs     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            shreg   <= dividend;
            rem     <= '0;
            dvs     <= divisor;
        end else if (running) begin
            shreg <= {shreg[W-2:0], fits};
            rem   <= rem_next;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(W - 1))
                running <= 1'b0;
        end
    end
endmodule

// File: rtl/term_next_unit.sv
// Next series term: term_out = (term_in * x_in) / n_in in signed Q5.11,
// one multiply cycle followed by a 16-cycle sequential divide.
module term_next_unit
    import fixp_defs::*;
#(
    parameter int W  = 16,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          custom_reset,
    input  logic          start,
    input  logic [W-1:0]  term_in,
    input  logic [W-1:0]  x_in,
    input  logic [NW-1:0] n_in,
    output logic          busy,
    output logic [W-1:0]  term_out,
    output logic          load,
    output logic          done,
    output logic          ovf,
    output logic          div_err
);
    logic [1:0]          state;
    logic signed [W-1:0] term_r;
    logic signed [W-1:0] x_r;
    logic [NW-1:0]       n_r;

    logic [2*W+1:0]      prod;
    logic [2*W+1:0]      prod_sh;
    logic [W-1:0]        mul_mag;
    logic                mul_sat;
    logic                sign;
    logic [W-1:0]        quotient;
    logic                q_valid;

    // |-32768| needs 17 bits, so magnitudes are widened before negation.
    function automatic logic [W:0] mag(input logic signed [W-1:0] v);
        return v[W-1] ? ((W+1)'(0) - {1'b1, v}) : {1'b0, v};
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] m, input logic s);
        return s ? (W'(0) - m) : m;
    endfunction

    always_comb begin
        prod    = mag(term_r) * mag(x_r);
        prod_sh = prod >> FRAC;
        mul_sat = |prod_sh[2*W+1:W-1];
        mul_mag = mul_sat ? MAXPOS : prod_sh[W-1:0];
        sign    = term_r[W-1] ^ x_r[W-1];
    end

    seq_divider #(.W(W), .NW(NW)) u_div (
        .clk          (clk),
        .custom_reset (custom_reset),
        .start        ((state == MUL) && (n_r != '0)),
        .dividend     (mul_mag),
        .divisor      (n_r),
        .quotient     (quotient),
        .q_valid      (q_valid)
    );

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            term_r <= term_in;
            x_r    <= x_in;
            n_r    <= n_in;
        end
    end

    always_ff @(posedge clk or posedge custom_reset) begin
        if (custom_reset) begin
            state    <= IDLE;
            term_out <= ONE;
            ovf      <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= MUL;
                    ovf     <= 1'b0;
                    div_err <= 1'b0;
                end
                MUL: begin
                    ovf <= mul_sat;
                    if (n_r == '0) begin
                        div_err  <= 1'b1;
                        term_out <= apply_sign(MAXPOS, sign);
                        state    <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: if (q_valid) begin
                    term_out <= apply_sign(quotient, sign);
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign load = (state == DONE);
    assign done = load;
endmodule
